// File: rtl/quad_step_decoder.sv
// quad_step_decoder
//
// Converts raw quadrature A/B lines into single-cycle inc/dec pulses for an
// up/down counter. Each raw channel passes through a two-flop synchroniser and
// a per-channel debounce filter. The decoder then follows Gray-code
// transitions of the debounced pair. An optional detent divider groups DIV
// sub-steps into one pulse. A transition where both channels change at once
// raises err and is never counted.
//
// Parameters
//   DEBOUNCE_CYCLES : cycles a synchronised channel must disagree with its
//                     stable value before the stable value follows (1..255)
//   DIV             : net quadrature sub-steps per emitted pulse (1, 2 or 4)
//
// Ports
//   clk   : system clock, rising edge
//   reset : synchronous, active-high reset
//   a_in  : raw channel A, asynchronous to clk
//   b_in  : raw channel B, asynchronous to clk
//   inc   : one-cycle pulse per net forward detent
//   dec   : one-cycle pulse per net reverse detent
//   err   : one-cycle pulse on an illegal double transition

module quad_step_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIV             = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic a_in,
    input  logic b_in,
    output logic inc,
    output logic dec,
    output logic err
);

    localparam logic [7:0]        DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    // INIT lasts DEBOUNCE_CYCLES+3 cycles: long enough for a level present at
    // reset release to cross the synchroniser and the debounce filter, so it
    // is captured into prev rather than decoded as a step.
    localparam logic [8:0]        INIT_LAST = 9'(DEBOUNCE_CYCLES + 2);
    localparam logic signed [2:0] ACC_MAX   = 3'(DIV - 1);
    localparam logic signed [2:0] ACC_MIN   = 3'(1 - DIV);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    // Synchroniser
    logic a_s1_q, a_s2_q, b_s1_q, b_s2_q;

    // Debounce
    logic [7:0] db_a_q, db_a_d, db_b_q, db_b_d;
    logic       stable_a_q, stable_a_d, stable_b_q, stable_b_d;

    // Decoder
    logic [0:0]        state_q, state_d;
    logic [8:0]        start_q, start_d;
    logic [1:0]        prev_q, prev_d;
    logic [1:0]        cur;
    logic signed [2:0] acc_q, acc_d;
    logic              inc_q, inc_d, dec_q, dec_d, err_q, err_d;

    // Returns {next_stable, next_count} for one debounce channel.
    function automatic logic [8:0] db_next(input logic s2, input logic stable,
                                           input logic [7:0] cnt);
        if (s2 == stable) begin
            return {stable, 8'd0};
        end else if (cnt == DB_LAST) begin
            return {s2, 8'd0};
        end else begin
            return {stable, cnt + 8'd1};
        end
    endfunction

    // Successor of a state in the forward Gray sequence 00->01->11->10->00.
    function automatic logic [1:0] fwd_next(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    assign {stable_a_d, db_a_d} = db_next(a_s2_q, stable_a_q, db_a_q);
    assign {stable_b_d, db_b_d} = db_next(b_s2_q, stable_b_q, db_b_q);
    assign cur = {stable_a_q, stable_b_q};

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        prev_d  = prev_q;
        acc_d   = acc_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_INIT: begin
                prev_d = cur;
                if (start_q == INIT_LAST) begin
                    state_d = ST_TRACK;
                end else begin
                    start_d = start_q + 9'd1;
                end
            end
            default: begin
                if (cur != prev_q) begin
                    prev_d = cur;
                    if ((cur ^ prev_q) == 2'b11) begin
                        // Both channels moved together: direction unknown,
                        // so discard any partial detent.
                        err_d = 1'b1;
                        acc_d = '0;
                    end else if (cur == fwd_next(prev_q)) begin
                        if (acc_q == ACC_MAX) begin
                            inc_d = 1'b1;
                            acc_d = '0;
                        end else begin
                            acc_d = acc_q + 3'sd1;
                        end
                    end else begin
                        // Only one bit changed and it is not forward, so it
                        // must be a reverse step.
                        if (acc_q == ACC_MIN) begin
                            dec_d = 1'b1;
                            acc_d = '0;
                        end else begin
                            acc_d = acc_q - 3'sd1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_s1_q     <= 1'b0;
            a_s2_q     <= 1'b0;
            b_s1_q     <= 1'b0;
            b_s2_q     <= 1'b0;
            db_a_q     <= '0;
            db_b_q     <= '0;
            stable_a_q <= 1'b0;
            stable_b_q <= 1'b0;
            state_q    <= ST_INIT;
            start_q    <= '0;
            prev_q     <= '0;
            acc_q      <= '0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            a_s1_q     <= a_in;
            a_s2_q     <= a_s1_q;
            b_s1_q     <= b_in;
            b_s2_q     <= b_s1_q;
            db_a_q     <= db_a_d;
            db_b_q     <= db_b_d;
            stable_a_q <= stable_a_d;
            stable_b_q <= stable_b_d;
            state_q    <= state_d;
            start_q    <= start_d;
            prev_q     <= prev_d;
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            err_q      <= err_d;
        end
    end

    assign inc = inc_q;
    assign dec = dec_q;
    assign err = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder
//
// Drives two decoder instances: dut0 (DEBOUNCE_CYCLES=4, DIV=1) and
// dut1 (DEBOUNCE_CYCLES=1, DIV=4). Each vector sets A/B, holds them for a
// number of cycles and compares the inc/dec/err pulses seen in that window
// against hand-computed counts. Latency, glitch, startup and reset cases are
// written out as short sequences.

module tb_quad_step_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, a0, b0, inc0, dec0, err0;
    logic rst1, a1, b1, inc1, dec1, err1;

    quad_step_decoder #(.DEBOUNCE_CYCLES(4), .DIV(1)) dut0 (
        .clk(clk), .reset(rst0), .a_in(a0), .b_in(b0),
        .inc(inc0), .dec(dec0), .err(err0)
    );

    quad_step_decoder #(.DEBOUNCE_CYCLES(1), .DIV(4)) dut1 (
        .clk(clk), .reset(rst1), .a_in(a1), .b_in(b1),
        .inc(inc1), .dec(dec1), .err(err1)
    );

    typedef struct {
        int   sel;
        logic a;
        logic b;
        int   hold;
        int   ei;
        int   ed;
        int   ee;
    } vec_t;

    vec_t tbl[34];

    int n_checks = 0;
    int n_fail   = 0;

    int c_inc[2] = '{0, 0};
    int c_dec[2] = '{0, 0};
    int c_err[2] = '{0, 0};
    int excl_viol  = 0;
    int width_viol = 0;
    logic [2:0] last0 = 3'b0;
    logic [2:0] last1 = 3'b0;

    // Pulse tally, exclusivity and one-cycle-width monitor.
    always @(negedge clk) begin
        if (inc0) c_inc[0]++;
        if (dec0) c_dec[0]++;
        if (err0) c_err[0]++;
        if (inc1) c_inc[1]++;
        if (dec1) c_dec[1]++;
        if (err1) c_err[1]++;
        if ((int'(inc0) + int'(dec0) + int'(err0)) > 1) excl_viol++;
        if ((int'(inc1) + int'(dec1) + int'(err1)) > 1) excl_viol++;
        if (({inc0, dec0, err0} & last0) != 3'b0) width_viol++;
        if (({inc1, dec1, err1} & last1) != 3'b0) width_viol++;
        last0 = {inc0, dec0, err0};
        last1 = {inc1, dec1, err1};
    end

    function automatic logic [2:0] outs(input int sel);
        return (sel == 0) ? {inc0, dec0, err0} : {inc1, dec1, err1};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic a, input logic b);
        if (sel == 0) begin
            a0 = a;
            b0 = b;
        end else begin
            a1 = a;
            b1 = b;
        end
    endtask

    task automatic window(input string name, input int sel, input int cycles,
                          input int ei, input int ed, input int ee);
        int si, sd, se, di, dd, de;
        si = c_inc[sel];
        sd = c_dec[sel];
        se = c_err[sel];
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        di = c_inc[sel] - si;
        dd = c_dec[sel] - sd;
        de = c_err[sel] - se;
        n_checks++;
        if (di != ei || dd != ed || de != ee) begin
            n_fail++;
            $display("FAIL %s: inc/dec/err got %0d/%0d/%0d, expected %0d/%0d/%0d",
                     name, di, dd, de, ei, ed, ee);
        end
    endtask

    task automatic apply(input string name, input int sel, input logic a,
                         input logic b, input int hold, input int ei,
                         input int ed, input int ee);
        drive(sel, a, b);
        window(name, sel, hold, ei, ed, ee);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].sel, tbl[i].a, tbl[i].b,
                  tbl[i].hold, tbl[i].ei, tbl[i].ed, tbl[i].ee);
        end
    endtask

    // Edges from the first sampling edge until the selected output (2=inc,
    // 1=dec, 0=err) is seen high; 99 if it never appears.
    task automatic measure(input int sel, input logic a, input logic b,
                           input int which, output int lat);
        logic [2:0] o;
        drive(sel, a, b);
        lat = 99;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            o = outs(sel);
            if (o[which] && lat == 99) lat = n - 1;
        end
    endtask

    initial begin
        int lat;

        // dut0: D=4, DIV=1, starting from absorbed 11 then one hand step to 10
        tbl[0]  = '{0, 1'b0, 1'b0, 10, 1, 0, 0};
        tbl[1]  = '{0, 1'b0, 1'b1, 10, 1, 0, 0};
        tbl[2]  = '{0, 1'b1, 1'b1, 10, 1, 0, 0};
        tbl[3]  = '{0, 1'b1, 1'b0, 10, 1, 0, 0};
        tbl[4]  = '{0, 1'b0, 1'b0, 10, 1, 0, 0};
        tbl[5]  = '{0, 1'b1, 1'b0, 10, 0, 1, 0};
        tbl[6]  = '{0, 1'b1, 1'b1, 10, 0, 1, 0};
        tbl[7]  = '{0, 1'b0, 1'b1, 10, 0, 1, 0};
        tbl[8]  = '{0, 1'b0, 1'b0, 10, 0, 1, 0};
        tbl[9]  = '{0, 1'b1, 1'b1, 10, 0, 0, 1};
        tbl[10] = '{0, 1'b1, 1'b0, 10, 1, 0, 0};
        tbl[11] = '{0, 1'b0, 1'b0, 10, 1, 0, 0};
        // dut1: D=1, DIV=4; three forward, three reverse, three forward
        tbl[12] = '{1, 1'b0, 1'b1, 6, 0, 0, 0};
        tbl[13] = '{1, 1'b1, 1'b1, 6, 0, 0, 0};
        tbl[14] = '{1, 1'b1, 1'b0, 6, 0, 0, 0};
        tbl[15] = '{1, 1'b1, 1'b1, 6, 0, 0, 0};
        tbl[16] = '{1, 1'b0, 1'b1, 6, 0, 0, 0};
        tbl[17] = '{1, 1'b0, 1'b0, 6, 0, 0, 0};
        tbl[18] = '{1, 1'b0, 1'b1, 6, 0, 0, 0};
        tbl[19] = '{1, 1'b1, 1'b1, 6, 0, 0, 0};
        tbl[20] = '{1, 1'b1, 1'b0, 6, 0, 0, 0};
        // dut1: two forward, illegal, three forward (no inc), then one more
        tbl[21] = '{1, 1'b0, 1'b1, 6, 0, 0, 0};
        tbl[22] = '{1, 1'b1, 1'b1, 6, 0, 0, 0};
        tbl[23] = '{1, 1'b0, 1'b0, 6, 0, 0, 1};
        tbl[24] = '{1, 1'b0, 1'b1, 6, 0, 0, 0};
        tbl[25] = '{1, 1'b1, 1'b1, 6, 0, 0, 0};
        tbl[26] = '{1, 1'b1, 1'b0, 6, 0, 0, 0};
        tbl[27] = '{1, 1'b0, 1'b0, 6, 1, 0, 0};
        // dut1: two forward, then mid reset, then four forward from 11
        tbl[28] = '{1, 1'b0, 1'b1, 6, 0, 0, 0};
        tbl[29] = '{1, 1'b1, 1'b1, 6, 0, 0, 0};
        tbl[30] = '{1, 1'b1, 1'b0, 6, 0, 0, 0};
        tbl[31] = '{1, 1'b0, 1'b0, 6, 0, 0, 0};
        tbl[32] = '{1, 1'b0, 1'b1, 6, 0, 0, 0};
        tbl[33] = '{1, 1'b1, 1'b1, 6, 1, 0, 0};

        rst0 = 1'b1; a0 = 1'b1; b0 = 1'b1;
        rst1 = 1'b1; a1 = 1'b0; b1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs_dut0", int'(outs(0)), 0);
        check("reset_outs_dut1", int'(outs(1)), 0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        check("startup_pulses_dut0", c_inc[0] + c_dec[0] + c_err[0], 0);
        check("startup_pulses_dut1", c_inc[1] + c_dec[1] + c_err[1], 0);

        // dut0 forward/reverse/illegal
        measure(0, 1'b1, 1'b0, 2, lat);
        check("inc_latency_d4", lat, 6);
        run_range(0, 11);

        // Glitch of three sampled cycles must not reach the stable value.
        drive(0, 1'b1, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        drive(0, 1'b0, 1'b0);
        window("glitch_reject", 0, 20, 0, 0, 0);
        apply("glitch_then_hold", 0, 1'b1, 1'b0, 20, 0, 1, 0);
        apply("illegal_10_01", 0, 1'b0, 1'b1, 10, 0, 0, 1);
        apply("rev_01_00", 0, 1'b0, 1'b0, 10, 0, 1, 0);

        // Reset lands exactly on the edge where the inc would be registered.
        drive(0, 1'b0, 1'b1);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_outs_dut0", int'(outs(0)), 0);
        rst0 = 1'b0;
        window("midreset_dropped", 0, 30, 0, 0, 0);
        apply("fresh_step_after_init", 0, 1'b1, 1'b1, 10, 1, 0, 0);

        // dut1 detent divider
        run_range(12, 20);
        measure(1, 1'b0, 1'b0, 2, lat);
        check("inc_latency_div4", lat, 3);
        run_range(21, 27);
        run_range(28, 29);
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_outs_dut1", int'(outs(1)), 0);
        rst1 = 1'b0;
        window("midreset_init_dut1", 1, 10, 0, 0, 0);
        run_range(30, 33);

        check("output_exclusivity", excl_viol, 0);
        check("pulse_width", width_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
